watch_time_bcd: RTL

Sequential binary-to-BCD converter for the watch time outputs. It snapshots the second, minute, hour and day counts on a start request and converts all four fields in parallel with a shift-add-3 (double-dabble) engine, one bit per cycle. It then presents packed BCD digits with a one-cycle valid pulse. It sits downstream of the watch counter block and upstream of the display/scan driver, and uses the same field widths and run-enable gating.

---
 rtl/watch_time_bcd.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/watch_time_bcd.sv
// Sequential binary-to-BCD converter for the watch time fields.
// Converts seconds, minutes, hours and days in parallel with a shared double-dabble step counter.
module watch_time_bcd #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_DAY_BIT  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run_en,
  input  logic        i_start,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic [P_DAY_BIT-1:0]  i_day,
  output logic        o_busy,
  output logic        o_valid,
  output logic [7:0]  o_sec_bcd,
  output logic [7:0]  o_min_bcd,
  output logic [7:0]  o_hour_bcd,
  output logic [11:0] o_day_bcd
);

  localparam int LP_N  = P_DAY_BIT;
  localparam int LP_CW = $clog2(LP_N + 1);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(LP_N - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [11:0] f_adj3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int k = 0; k < 3; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_t            r_state, w_state_next;
  logic [LP_CW-1:0]  r_cnt;
  logic [LP_N-1:0]   r_sec_snap, r_min_snap, r_hour_snap, r_day_snap;
  logic [7:0]        r_sec_sc, r_min_sc, r_hour_sc;
  logic [11:0]       r_day_sc;
  logic              r_busy, r_valid;
  logic [7:0]        r_sec_bcd, r_min_bcd, r_hour_bcd;
  logic [11:0]       r_day_bcd;

  logic              w_load, w_step, w_done;
  logic [7:0]        w_sec_adj, w_min_adj, w_hour_adj;
  logic [11:0]       w_day_adj;
  logic [7:0]        w_sec_shift, w_min_shift, w_hour_shift;
  logic [11:0]       w_day_shift;

  assign w_sec_adj    = 8'(f_adj3({4'd0, r_sec_sc}));
  assign w_min_adj    = 8'(f_adj3({4'd0, r_min_sc}));
  assign w_hour_adj   = 8'(f_adj3({4'd0, r_hour_sc}));
  assign w_day_adj    = f_adj3(r_day_sc);
  assign w_sec_shift  = 8'({w_sec_adj, r_sec_snap[LP_N-1]});
  assign w_min_shift  = 8'({w_min_adj, r_min_snap[LP_N-1]});
  assign w_hour_shift = 8'({w_hour_adj, r_hour_snap[LP_N-1]});
  assign w_day_shift  = 12'({w_day_adj, r_day_snap[LP_N-1]});

  // The final step also accepts a held start, sustaining one result every N cycles.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run_en && i_start) begin
          w_state_next = S_CONV;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CONV: begin
        if (i_run_en) begin
          w_step = 1'b1;
          if (r_cnt == LP_LAST) begin
            w_done = 1'b1;
            if (i_start) begin
              w_state_next = S_CONV;
              w_load       = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_state_next = S_CONV;
          end
        end else begin
          w_state_next = S_CONV;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sec_snap  <= '0;
      r_min_snap  <= '0;
      r_hour_snap <= '0;
      r_day_snap  <= '0;
      r_sec_sc    <= 8'd0;
      r_min_sc    <= 8'd0;
      r_hour_sc   <= 8'd0;
      r_day_sc    <= 12'd0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_sec_bcd   <= 8'd0;
      r_min_bcd   <= 8'd0;
      r_hour_bcd  <= 8'd0;
      r_day_bcd   <= 12'd0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_CONV);
      r_valid <= w_done;
      if (w_load) begin
        r_sec_snap  <= LP_N'(i_sec);
        r_min_snap  <= LP_N'(i_min);
        r_hour_snap <= LP_N'(i_hour);
        r_day_snap  <= LP_N'(i_day);
        r_sec_sc    <= 8'd0;
        r_min_sc    <= 8'd0;
        r_hour_sc   <= 8'd0;
        r_day_sc    <= 12'd0;
        r_cnt       <= '0;
      end else if (w_step) begin
        r_sec_snap  <= {r_sec_snap[LP_N-2:0], 1'b0};
        r_min_snap  <= {r_min_snap[LP_N-2:0], 1'b0};
        r_hour_snap <= {r_hour_snap[LP_N-2:0], 1'b0};
        r_day_snap  <= {r_day_snap[LP_N-2:0], 1'b0};
        r_sec_sc    <= w_sec_shift;
        r_min_sc    <= w_min_shift;
        r_hour_sc   <= w_hour_shift;
        r_day_sc    <= w_day_shift;
        r_cnt       <= r_cnt + LP_CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_done) begin
        r_sec_bcd  <= w_sec_shift;
        r_min_bcd  <= w_min_shift;
        r_hour_bcd <= w_hour_shift;
        r_day_bcd  <= w_day_shift;
      end else begin
        r_sec_bcd  <= r_sec_bcd;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_valid    = r_valid;
  assign o_sec_bcd  = r_sec_bcd;
  assign o_min_bcd  = r_min_bcd;
  assign o_hour_bcd = r_hour_bcd;
  assign o_day_bcd  = r_day_bcd;

endmodule
